// File: rtl/dac_waveform_player_pkg.sv
// Shared types and helpers for the DAC waveform player: FSM encoding, idle word and
// the sample left-justify mask.
package dac_waveform_player_pkg;

  localparam int unsigned MaxDataW = 256;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPlay,
    StDrain
  } state_e;

  localparam logic [MaxDataW-1:0] IdleWord = '0;

  // Keeps only the DAC_WIDTH upper bits of every sample container in a stream word.
  function automatic logic [MaxDataW-1:0] justify_mask(input int unsigned dac_w,
                                                       input int unsigned samp_w,
                                                       input int unsigned spc);
    logic [MaxDataW-1:0] m;
    logic [MaxDataW-1:0] one;
    m   = '0;
    one = MaxDataW'(1);
    for (int unsigned s = 0; s < spc; s++) begin
      m = m | (((one << dac_w) - one) << (s * samp_w + (samp_w - dac_w)));
    end
    return m;
  endfunction

endpackage

// File: rtl/dac_waveform_player_ram.sv
// Simple dual-port sample table: one write port, one registered read port with enable.
// Read-during-write to the same address returns the old contents.
module dac_waveform_player_ram
  import dac_waveform_player_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // No reset on the read register so it maps onto the block RAM output latch.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dac_waveform_player.sv
// Plays a processor-loaded sample table into one DAC AXI-Stream channel, with
// arm/trigger control, loop counting and abort.
module dac_waveform_player
  import dac_waveform_player_pkg::*;
#(
  parameter int unsigned DAC_WIDTH        = 14,
  parameter int unsigned DAC_SAMPLE_WIDTH = 16,
  parameter int unsigned SAMPLES_PER_CLK  = 2,
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned LOOP_WIDTH       = 16
) (
  input  logic                                        dacClk,
  input  logic                                        dacReset,
  input  logic                                        tableWrEnable,
  input  logic [ADDR_WIDTH-1:0]                       tableWrAddr,
  input  logic [SAMPLES_PER_CLK*DAC_SAMPLE_WIDTH-1:0] tableWrData,
  input  logic [ADDR_WIDTH-1:0]                       lastAddr,
  input  logic [LOOP_WIDTH-1:0]                       loopCount,
  input  logic                                        arm,
  input  logic                                        trigger,
  input  logic                                        abort,
  output logic [SAMPLES_PER_CLK*DAC_SAMPLE_WIDTH-1:0] dacTDATA,
  output logic                                        dacTVALID,
  input  logic                                        dacTREADY,
  output logic                                        armed,
  output logic                                        busy,
  output logic                                        done,
  output logic [LOOP_WIDTH-1:0]                       passCount
);

  localparam int unsigned DataW = SAMPLES_PER_CLK * DAC_SAMPLE_WIDTH;
  localparam logic [DataW-1:0] JustifyMask =
    DataW'(justify_mask(DAC_WIDTH, DAC_SAMPLE_WIDTH, SAMPLES_PER_CLK));

  state_e                r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_d;
  logic [ADDR_WIDTH-1:0] r_last, w_last_d;
  logic [LOOP_WIDTH-1:0] r_loop, w_loop_d;
  logic [LOOP_WIDTH-1:0] r_pass, w_pass_d, w_pass_inc;
  logic                  r_drain, w_drain_d;
  logic                  r_done, w_done_d;
  logic                  r_s1_tag;
  logic [DataW-1:0]      r_dout;
  logic                  r_valid;
  logic [DataW-1:0]      w_ram_data;
  logic                  w_adv;

  assign w_adv = dacTREADY;

  dac_waveform_player_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DataW)
  ) u_ram (
    .i_clk    (dacClk),
    .i_wr_en  (tableWrEnable),
    .i_wr_addr(tableWrAddr),
    .i_wr_data(tableWrData),
    .i_rd_en  (w_adv),
    .i_rd_addr(r_rd_addr),
    .o_rd_data(w_ram_data)
  );

  assign w_pass_inc = (r_pass == '1) ? r_pass : r_pass + LOOP_WIDTH'(1);

  always_comb begin
    w_state_d   = r_state;
    w_rd_addr_d = r_rd_addr;
    w_last_d    = r_last;
    w_loop_d    = r_loop;
    w_pass_d    = r_pass;
    w_drain_d   = r_drain;
    w_done_d    = 1'b0;
    if (abort) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: if (arm) w_state_d = StArmed;
        StArmed: begin
          if (trigger) begin
            w_state_d   = StPlay;
            w_last_d    = lastAddr;
            w_loop_d    = loopCount;
            w_rd_addr_d = '0;
            w_pass_d    = '0;
          end
        end
        StPlay: begin
          if (w_adv) begin
            if (r_rd_addr == r_last) begin
              w_rd_addr_d = '0;
              w_pass_d    = w_pass_inc;
              if ((r_loop != '0) && (w_pass_inc == r_loop)) begin
                w_state_d = StDrain;
                w_drain_d = 1'b0;
              end
            end else begin
              w_rd_addr_d = r_rd_addr + ADDR_WIDTH'(1);
            end
          end
        end
        StDrain: begin
          // Two advances: the last word enters stage 2, then it is replaced by idle.
          if (w_adv) begin
            if (r_drain) begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
            end else begin
              w_drain_d = 1'b1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge dacClk or posedge dacReset) begin
    if (dacReset) begin
      r_state   <= StIdle;
      r_rd_addr <= '0;
      r_last    <= '0;
      r_loop    <= '0;
      r_pass    <= '0;
      r_drain   <= 1'b0;
      r_done    <= 1'b0;
      r_s1_tag  <= 1'b0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_rd_addr <= w_rd_addr_d;
      r_last    <= w_last_d;
      r_loop    <= w_loop_d;
      r_pass    <= w_pass_d;
      r_drain   <= w_drain_d;
      r_done    <= w_done_d;
      r_valid   <= 1'b1;
      if (abort) r_s1_tag <= 1'b0;
      else if (w_adv) r_s1_tag <= (r_state == StPlay);
      if (w_adv) begin
        r_dout <= (r_s1_tag && !abort) ? (w_ram_data & JustifyMask) : IdleWord[DataW-1:0];
      end
    end
  end

  assign dacTDATA  = r_dout;
  assign dacTVALID = r_valid;
  assign armed     = (r_state == StArmed);
  assign busy      = (r_state == StPlay) || (r_state == StDrain);
  assign done      = r_done;
  assign passCount = r_pass;

endmodule
